// File: rtl/uib_intc_pkg.sv
// Shared definitions for the uib interrupt controller: register offsets,
// bus FSM states, access decode and the claim-id width helper.
package uib_intc_pkg;

  localparam logic [1:0] REG_PENDING   = 2'd0;
  localparam logic [1:0] REG_ENABLE    = 2'd1;
  localparam logic [1:0] REG_CLAIM     = 2'd2;
  localparam logic [1:0] REG_INSERVICE = 2'd3;

  // Full 32-bit word access encoding on the uib mode field.
  localparam logic [2:0] MODE_WORD = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK  = 2'd1,
    HOLD = 2'd2
  } bus_state_e;

  typedef struct packed {
    logic       hit;
    logic       word;
    logic [1:0] sel;
  } acc_dec_t;

  function automatic int unsigned id_width(input int unsigned nsrc);
    return $clog2(nsrc + 1);
  endfunction

endpackage

// File: rtl/uib_intc_prio.sv
// Lowest-index-first priority encoder; id is index+1, 0 when nothing is set.
module uib_intc_prio #(
  parameter int unsigned NSRC = 8,
  parameter int unsigned IDW  = 4
) (
  input  logic [NSRC-1:0] vec_i,
  output logic            valid_c_o,
  output logic [IDW-1:0]  id_c_o
);

  assign valid_c_o = |vec_i;

  // Scan high to low so the lowest set index is written last and wins.
  always_comb begin
    id_c_o = '0;
    for (int i = int'(NSRC) - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        id_c_o = IDW'(i + 1);
      end
    end
  end

endmodule

// File: rtl/uib_intc.sv
// uib slave interrupt controller: latched pending/enable/in-service per source,
// claim/complete through registers and one registered intr line to the cpu.
module uib_intc
  import uib_intc_pkg::*;
#(
  parameter int unsigned     XLEN      = 32,
  parameter int unsigned     ADDR_W    = 28,
  parameter int unsigned     NSRC      = 8,
  parameter logic [NSRC-1:0] EDGE_MASK = {NSRC{1'b1}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              wen,
  input  logic [ADDR_W-1:0] addr,
  input  logic [2:0]        mode,
  input  logic [XLEN-1:0]   dat_i,
  output logic [XLEN-1:0]   dat_o,
  output logic              ready,
  input  logic [NSRC-1:0]   src,
  output logic              intr
);

  localparam int unsigned IDW = id_width(NSRC);

  bus_state_e        state_q, state_d;
  logic [NSRC-1:0]   pending_q, pending_d;
  logic [NSRC-1:0]   enable_q, enable_d;
  logic [NSRC-1:0]   insvc_q, insvc_d;
  logic [NSRC-1:0]   src_q;
  logic [XLEN-1:0]   dat_q, dat_d;
  logic              ready_q;
  logic              intr_q, intr_d;

  acc_dec_t          dec_c;
  logic [NSRC-1:0]   claim_vec_c;
  logic [NSRC-1:0]   claim_onehot_c;
  logic [NSRC-1:0]   cmpl_onehot_c;
  logic [NSRC-1:0]   rise_c;
  logic              claim_valid_c;
  logic [IDW-1:0]    claim_id_c;
  logic              cmpl_ok_c;
  logic [XLEN-1:0]   rdata_c;
  logic [NSRC-1:0]   w1c_clr;
  logic [NSRC-1:0]   claim_set;
  logic [NSRC-1:0]   cmpl_clr;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^addr[1:0];

  assign dec_c = '{hit:  (addr[ADDR_W-1:4] == '0),
                   word: (mode == MODE_WORD),
                   sel:  addr[3:2]};

  assign claim_vec_c    = pending_q & enable_q & ~insvc_q;
  assign rise_c         = src & ~src_q;
  assign claim_onehot_c = NSRC'(1) << (claim_id_c - IDW'(1));
  assign cmpl_onehot_c  = NSRC'(1) << (dat_i[IDW-1:0] - IDW'(1));
  assign cmpl_ok_c      = (dat_i != '0) && (dat_i <= XLEN'(NSRC));

  uib_intc_prio #(
    .NSRC (NSRC),
    .IDW  (IDW)
  ) u_prio (
    .vec_i     (claim_vec_c),
    .valid_c_o (claim_valid_c),
    .id_c_o    (claim_id_c)
  );

  // Read mux; upper bits are zero-extended and unmapped addresses read 0.
  always_comb begin
    rdata_c = '0;
    if (dec_c.hit) begin
      case (dec_c.sel)
        REG_PENDING:   rdata_c = XLEN'(pending_q);
        REG_ENABLE:    rdata_c = XLEN'(enable_q);
        REG_CLAIM:     rdata_c = XLEN'(claim_id_c);
        REG_INSERVICE: rdata_c = XLEN'(insvc_q);
        default:       rdata_c = '0;
      endcase
    end
  end

  // Bus FSM plus all register side effects, performed in the IDLE capture cycle.
  always_comb begin
    state_d   = state_q;
    enable_d  = enable_q;
    dat_d     = dat_q;
    w1c_clr   = '0;
    claim_set = '0;
    cmpl_clr  = '0;

    case (state_q)
      IDLE: begin
        if (req) begin
          state_d = ACK;
          dat_d   = wen ? '0 : rdata_c;
          if (dec_c.hit && dec_c.word) begin
            if (wen) begin
              case (dec_c.sel)
                REG_PENDING: w1c_clr  = dat_i[NSRC-1:0] & EDGE_MASK;
                REG_ENABLE:  enable_d = dat_i[NSRC-1:0];
                REG_CLAIM:   cmpl_clr = cmpl_ok_c ? cmpl_onehot_c : '0;
                default:     w1c_clr  = '0;
              endcase
            end else if ((dec_c.sel == REG_CLAIM) && claim_valid_c) begin
              claim_set = claim_onehot_c;
            end
          end
        end
      end
      ACK:     state_d = HOLD;
      HOLD:    state_d = req ? HOLD : IDLE;
      default: state_d = IDLE;
    endcase

    insvc_d   = (insvc_q & ~cmpl_clr) | claim_set;
    // A same-cycle edge overrides a W1C or claim clear on that bit.
    pending_d = (EDGE_MASK & ((pending_q & ~(w1c_clr | (claim_set & EDGE_MASK))) | rise_c))
              | (~EDGE_MASK & src_q);
    intr_d    = |claim_vec_c;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
      enable_q  <= '0;
      insvc_q   <= '0;
      src_q     <= '0;
      dat_q     <= '0;
      ready_q   <= 1'b0;
      intr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      enable_q  <= enable_d;
      insvc_q   <= insvc_d;
      src_q     <= src;
      dat_q     <= dat_d;
      ready_q   <= (state_d == ACK);
      intr_q    <= intr_d;
    end
  end

  assign dat_o = dat_q;
  assign ready = ready_q;
  assign intr  = intr_q;

endmodule

// File: tb/tb_uib_intc.sv
// Randomized self-checking bench for uib_intc against a transaction-level
// model of pending/enable/in-service state.
module tb_uib_intc;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned ADDR_W = 28;
  localparam int unsigned NSRC   = 8;
  localparam logic [7:0]  EDGE   = 8'hFE;
  localparam logic [2:0]  MW     = 3'b010;

  logic              clk = 1'b0;
  logic              rst;
  logic              req;
  logic              wen;
  logic [ADDR_W-1:0] addr;
  logic [2:0]        mode;
  logic [XLEN-1:0]   dat_i;
  logic [XLEN-1:0]   dat_o;
  logic              ready;
  logic [NSRC-1:0]   src;
  logic              intr;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] m_pend, m_en, m_isv;
  logic       lvl;

  uib_intc #(
    .XLEN      (XLEN),
    .ADDR_W    (ADDR_W),
    .NSRC      (NSRC),
    .EDGE_MASK (EDGE)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .wen   (wen),
    .addr  (addr),
    .mode  (mode),
    .dat_i (dat_i),
    .dat_o (dat_o),
    .ready (ready),
    .src   (src),
    .intr  (intr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int lowest_id(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i + 1;
    return 0;
  endfunction

  function automatic logic [27:0] ra(input logic [1:0] sel);
    logic [27:0] a;
    a = '0;
    a[3:2] = sel;
    return a;
  endfunction

  function automatic logic [31:0] exp_intr();
    return {31'd0, |(m_pend & m_en & ~m_isv)};
  endfunction

  task automatic bus(input logic w, input logic [27:0] a, input logic [2:0] m,
                     input logic [31:0] wd, input logic [7:0] pulse,
                     output logic [31:0] rd);
    int lat;
    bit seen;
    @(posedge clk); #1;
    req = 1'b1; wen = w; addr = a; mode = m; dat_i = wd;
    src = src | pulse;
    lat = 0; seen = 0; rd = '0;
    for (int k = 0; k < 8 && !seen; k++) begin
      @(posedge clk); #1;
      lat++;
      if (ready) begin
        seen = 1;
        rd = dat_o;
      end
    end
    check("ready_latency", seen ? lat : 99, 1);
    @(posedge clk); #1;
    check("ready_one_cycle", {31'd0, ready}, 0);
    req = 1'b0;
    src = src & ~pulse;
  endtask

  task automatic settle_intr(input string tag);
    repeat (3) @(posedge clk);
    #1;
    check(tag, {31'd0, intr}, exp_intr());
  endtask

  // One bus access: model predicts the read value and side effects first.
  task automatic op(input logic w, input logic [27:0] a, input logic [2:0] m,
                    input logic [31:0] wd, input logic [7:0] pulse, input string tag);
    logic [31:0] expv, rd;
    logic [1:0]  sel;
    logic        hit, word;
    int          cid;
    logic [7:0]  bitm;
    sel  = a[3:2];
    hit  = (a[27:4] == 24'd0);
    word = (m == MW);
    cid  = lowest_id(m_pend & m_en & ~m_isv);
    expv = '0;
    if (!w) begin
      if (hit) begin
        case (sel)
          2'd0: expv = 32'(m_pend);
          2'd1: expv = 32'(m_en);
          2'd2: expv = 32'(cid);
          default: expv = 32'(m_isv);
        endcase
        if (word && sel == 2'd2 && cid != 0) begin
          bitm   = 8'(1) << (cid - 1);
          m_isv  = m_isv | bitm;
          m_pend = m_pend & ~(bitm & EDGE);
        end
      end
    end else if (hit && word) begin
      case (sel)
        2'd0: m_pend = m_pend & ~(wd[7:0] & EDGE);
        2'd1: m_en = wd[7:0];
        2'd2: if (wd >= 1 && wd <= 8) m_isv = m_isv & ~(8'(1) << (wd - 1));
        default: ;
      endcase
    end
    bus(w, a, m, wd, pulse, rd);
    m_pend = m_pend | (pulse & EDGE);
    if (!w) check(tag, rd, expv);
    settle_intr({tag, "_intr"});
  endtask

  task automatic pulse_src(input logic [7:0] mask);
    @(posedge clk); #1;
    src = src | mask;
    @(posedge clk); #1;
    src = src & ~mask;
    m_pend = m_pend | (mask & EDGE);
    settle_intr("pulse_intr");
  endtask

  task automatic set_level(input logic v);
    @(posedge clk); #1;
    src[0] = v;
    lvl = v;
    m_pend[0] = v;
    repeat (2) @(posedge clk);
    settle_intr("level_intr");
  endtask

  initial begin
    logic [31:0] rd, wd;
    logic [7:0]  p;
    logic [2:0]  sm;
    int          nrdy, cid, r;

    rst = 1'b0; req = 1'b0; wen = 1'b0; addr = '0; mode = MW; dat_i = '0; src = '0;
    m_pend = '0; m_en = '0; m_isv = '0; lvl = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {31'd0, ready}, 0);
    check("rst_intr", {31'd0, intr}, 0);
    check("rst_dat_o", dat_o, 0);
    rst = 1'b1;

    for (int s = 0; s < 4; s++) op(1'b0, ra(2'(s)), MW, 0, 0, "rst_reg");
    op(1'b1, ra(2'd1), MW, 32'hFF, 0, "en_wr");
    op(1'b0, ra(2'd1), MW, 0, 0, "en_rd");

    // Edge source with intr timing one cycle after pending.
    op(1'b1, ra(2'd1), MW, 32'h04, 0, "en_04");
    @(posedge clk); #1; src[2] = 1'b1;
    @(posedge clk); #1; src[2] = 1'b0;
    m_pend[2] = 1'b1;
    check("edge_intr_lag", {31'd0, intr}, 0);
    @(posedge clk); #1;
    check("edge_intr_set", {31'd0, intr}, 1);
    op(1'b0, ra(2'd0), MW, 0, 0, "edge_pend");
    op(1'b0, ra(2'd2), MW, 0, 0, "edge_claim");
    op(1'b0, ra(2'd0), MW, 0, 0, "edge_pend_clr");
    op(1'b0, ra(2'd3), MW, 0, 0, "edge_isv");
    op(1'b1, ra(2'd2), MW, 3, 0, "edge_cmpl");
    op(1'b0, ra(2'd3), MW, 0, 0, "edge_isv_clr");

    // Priority and nesting.
    op(1'b1, ra(2'd1), MW, 32'hFF, 0, "en_ff");
    pulse_src(8'h22);
    op(1'b0, ra(2'd2), MW, 0, 0, "prio_claim_a");
    op(1'b0, ra(2'd2), MW, 0, 0, "prio_claim_b");
    op(1'b0, ra(2'd2), MW, 0, 0, "prio_claim_none");
    op(1'b1, ra(2'd2), MW, 2, 0, "prio_cmpl");
    op(1'b0, ra(2'd3), MW, 0, 0, "prio_isv");
    op(1'b1, ra(2'd2), MW, 6, 0, "prio_cmpl6");

    // Level source.
    set_level(1'b1);
    op(1'b0, ra(2'd2), MW, 0, 0, "lvl_claim");
    op(1'b1, ra(2'd2), MW, 1, 0, "lvl_cmpl");
    op(1'b0, ra(2'd0), MW, 0, 0, "lvl_pend_high");
    set_level(1'b0);
    op(1'b0, ra(2'd0), MW, 0, 0, "lvl_pend_low");

    // Boundaries.
    pulse_src(8'h10);
    op(1'b1, ra(2'd0), MW, 32'h10, 8'h10, "w1c_vs_edge");
    op(1'b0, ra(2'd0), MW, 0, 0, "w1c_set_wins");
    op(1'b1, ra(2'd0), MW, 32'hFF, 0, "w1c_all");
    op(1'b0, ra(2'd0), MW, 0, 0, "w1c_pend");
    pulse_src(8'h08);
    op(1'b0, ra(2'd2), MW, 0, 0, "bnd_claim");
    op(1'b1, ra(2'd2), MW, 0, 0, "cmpl_id0");
    op(1'b1, ra(2'd2), MW, 9, 0, "cmpl_id9");
    op(1'b0, ra(2'd3), MW, 0, 0, "bnd_isv");
    op(1'b0, 28'h10, MW, 0, 0, "unmapped_rd");
    op(1'b1, 28'h14, MW, 32'hFF, 0, "unmapped_wr");
    op(1'b1, ra(2'd1), 3'b000, 32'h00, 0, "subword_wr");
    op(1'b0, ra(2'd1), MW, 0, 0, "subword_en");
    op(1'b1, ra(2'd2), MW, 4, 0, "bnd_cmpl");

    // Handshake: req held five cycles gives one ready and one claim.
    pulse_src(8'h06);
    cid = lowest_id(m_pend & m_en & ~m_isv);
    m_isv  = m_isv | (8'(1) << (cid - 1));
    m_pend = m_pend & ~((8'(1) << (cid - 1)) & EDGE);
    @(posedge clk); #1;
    req = 1'b1; wen = 1'b0; addr = ra(2'd2); mode = MW;
    nrdy = 0; rd = '0;
    repeat (5) begin
      @(posedge clk); #1;
      if (ready) begin nrdy++; rd = dat_o; end
    end
    req = 1'b0;
    check("hs_ready_count", nrdy, 1);
    check("hs_claim_id", rd, 32'(cid));
    op(1'b0, ra(2'd3), MW, 0, 0, "hs_isv");
    op(1'b0, ra(2'd2), MW, 0, 0, "hs_claim2");
    op(1'b1, ra(2'd2), MW, 2, 0, "hs_cmpl2");
    op(1'b1, ra(2'd2), MW, 3, 0, "hs_cmpl3");

    // Reset during ACK.
    pulse_src(8'h08);
    @(posedge clk); #1;
    req = 1'b1; wen = 1'b0; addr = ra(2'd2); mode = MW;
    @(posedge clk); #1;
    check("rstack_ready_pre", {31'd0, ready}, 1);
    rst = 1'b0;
    #1;
    check("rstack_ready", {31'd0, ready}, 0);
    check("rstack_intr", {31'd0, intr}, 0);
    check("rstack_dat_o", dat_o, 0);
    req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    m_pend = '0; m_en = '0; m_isv = '0;
    for (int s = 0; s < 4; s++) op(1'b0, ra(2'(s)), MW, 0, 0, "rstack_reg");

    // Randomized traffic.
    for (int it = 0; it < 250; it++) begin
      r  = $urandom_range(0, 8);
      p  = 8'($urandom) & EDGE;
      wd = $urandom;
      case (r)
        0: if (p != 0) pulse_src(p);
        1: set_level(~lvl);
        2: op(1'b1, ra(2'd1), MW, wd, ($urandom_range(0, 3) == 0) ? p : 8'h0, "rnd_en");
        3, 4: op(1'b0, ra(2'd2), MW, 0, ($urandom_range(0, 3) == 0) ? p : 8'h0, "rnd_claim");
        5: begin
          if (m_isv != 0 && $urandom_range(0, 1) == 1) wd = 32'(lowest_id(m_isv));
          else wd = 32'($urandom_range(0, 9));
          op(1'b1, ra(2'd2), MW, wd, 0, "rnd_cmpl");
        end
        6: op(1'b1, ra(2'd0), MW, wd, ($urandom_range(0, 3) == 0) ? p : 8'h0, "rnd_w1c");
        7: begin
          if ($urandom_range(0, 9) == 0)
            op(1'b0, 28'($urandom_range(1, 255)) << 4, MW, 0, 0, "rnd_unmapped");
          else
            op(1'b0, ra(2'($urandom_range(0, 3))), MW, 0, 0, "rnd_read");
        end
        default: begin
          case ($urandom_range(0, 3))
            0: sm = 3'b000;
            1: sm = 3'b001;
            2: sm = 3'b100;
            default: sm = 3'b101;
          endcase
          op(1'($urandom_range(0, 1)), ra(2'($urandom_range(0, 3))), sm, wd, 0, "rnd_subword");
        end
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uib_intc.md
Name: uib_intc

Overview:
- Parametrised interrupt controller that sits as a standard uib slave.
- Replaces the single hard-wired timer-to-CPU intr line with NSRC prioritised sources (timer, uart, future peripherals).
- Per-source latched pending, enable and in-service bits.
- Claim/complete protocol through memory-mapped registers; one aggregated intr output to the cpu.

Parameters:
- XLEN, 32, data width of the bus.
- ADDR_W, 28, slave address width (XLEN - SLAVE_WIDTH).
- NSRC, 8, number of interrupt sources (1..31).
- EDGE_MASK, {NSRC{1'b1}}, per-source trigger type: 1 = rising edge, 0 = level.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- req  input  1  bus request, held until ready is seen.
- wen  input  1  1 = write, 0 = read.
- addr  input  ADDR_W  byte address within the slave window.
- mode  input  3  access size; only full-word access has effect.
- dat_i  input  XLEN  write data.
- dat_o  output  XLEN  read data, valid while ready = 1.
- ready  output  1  one-cycle completion strobe.
- src  input  NSRC  interrupt sources, synchronous to clk.
- intr  output  1  aggregated interrupt to the cpu, registered.

Behaviour:
- Reset (rst low, async): pending, enable, in_service, src_q and dat_o = 0; ready = 0; intr = 0; FSM = IDLE.
- A reset mid-access abandons the access with no side effect.
- Register map (decode on addr[3:2]; addr[ADDR_W-1:4] != 0 means unmapped):
  - 0x0 PENDING: read pending. Write-1-to-clear for edge sources only; level bits ignore writes.
  - 0x4 ENABLE: read/write, low NSRC bits.
  - 0x8 CLAIM: a read returns id = index+1 of the lowest-index bit of (pending & enable & ~in_service), or 0 if none. On nonzero id, the same cycle sets in_service[index] and clears pending[index] if that source is edge type. A write of id completes: clears in_service[id-1]. id 0, id > NSRC, or a source not in service is ignored.
  - 0xC INSERVICE: read-only.
- Unmapped addresses read 0, ignore writes, and still return ready.
- Upper read bits (XLEN-1:NSRC) are 0.
- Any sub-word mode: the write is ignored; a read returns the full word. CLAIM side effects occur on word reads only.
- Source capture:
  - src_q <= src every cycle.
  - Edge source: pending set on src & ~src_q.
  - Level source: pending = src_q every cycle.
  - Edge set in the same cycle as a W1C clear or a claim clear: set wins.
- intr <= |(pending & enable & ~in_service), registered, so it trails the pending update by 1 cycle.
- Bus FSM:
  - IDLE: when req = 1, capture addr/wen/mode/dat_i, perform the access and its side effects in this cycle, load dat_o, go to ACK.
  - ACK: ready = 1 for exactly one cycle, dat_o valid; go to HOLD.
  - HOLD: ready = 0; return to IDLE only once req = 0. This guarantees one side effect per access.
  - Latency from req to ready is 1 cycle; minimum back-to-back spacing is 3 cycles.
- dat_o holds its last value outside ACK.
- The claim id is computed from registered state in the capture cycle. A source edge arriving in that same cycle stays pending for a later claim.
- Nesting: a higher-priority source may be claimed while a lower one is in service. In-service bits are independent.

Decomposition:
- Package uib_intc_pkg:
  - register offsets REG_PENDING / REG_ENABLE / REG_CLAIM / REG_INSERVICE.
  - FSM enum {IDLE, ACK, HOLD}.
  - claim id width function clog2(NSRC+1).
- Sub-module uib_intc_prio: parametrised lowest-index-first priority encoder (NSRC-bit vector in; valid and id out). Used for the CLAIM read.

Test Plan:
- Reset: assert rst = 0 mid-ACK -> ready = 0, intr = 0, all registers read 0 after release; ENABLE write 0xFF then read -> 0x000000FF.
- Edge source: ENABLE = 0x04, pulse src[2] for 1 cycle -> PENDING = 0x04 and intr = 1 one cycle later. CLAIM read -> 3, PENDING = 0, INSERVICE = 0x04, intr = 0. Write CLAIM = 3 -> INSERVICE = 0.
- Priority: ENABLE = 0xFF, pulse src[5] and src[1] together -> CLAIM read 2, then 6, then 0. Complete 2 only -> INSERVICE = 0x20.
- Level source (EDGE_MASK bit0 = 0): hold src[0] = 1, claim -> 1, intr = 0. Complete while still high -> intr = 1 again. Drop src[0] -> PENDING[0] = 0, intr = 0.
- Boundaries: W1C PENDING on the same cycle as a new edge on that bit -> bit stays 1. Complete id 0 or NSRC+1 -> no change. Unmapped address 0x10 -> read 0 with ready after 1 cycle.
- Handshake: hold req high 5 cycles -> exactly one ready pulse and one claim side effect. Back-to-back CLAIM reads need req low between them.
